taxi_fare_calc: RTL and testbench
=================================

TAXI_FARE_CALC -- requirements
Module: taxi_fare_calc

Interface
REQ-001 Parameter PULSES_PER_STEP, default 10: wheel-sensor pulses per 0.1 km distance step.
REQ-002 Parameter BASE_FARE, default 16'h0100: BCD starting fare in 0.1-yuan units (010.0).
REQ-003 Parameter BASE_STEPS, default 30: distance steps (0.1 km each) covered by the base fare.
REQ-004 Parameter STEP_FARE, default 2: BCD digit 1..9, fare added per step beyond BASE_STEPS.
REQ-005 Parameter IDLE_CYCLES, default 250_000_000: clocks without a pulse before entering WAIT.
REQ-006 Parameter WAIT_UNIT, default 500_000_000: clocks per waiting charge while in WAIT.
REQ-007 Parameter WAIT_FARE, default 1: BCD digit 1..9, fare added per elapsed WAIT_UNIT.
REQ-008 clk_50m  input  1  system clock, 50 MHz; the block uses one clock.
REQ-009 rst_n  input  1  reset, asynchronous, active-low.
REQ-010 sw_start  input  1  meter flag, asynchronous level; high = trip active.
REQ-011 pulse_in  input  1  wheel sensor, asynchronous; one rising edge per wheel revolution.
REQ-012 fare_bcd  output  16  fare as 4 BCD digits [15:12]..[3:0], 0.1-yuan units, 000.0..999.9.
REQ-013 dist_bcd  output  16  distance as 4 BCD digits, 0.1-km units, 000.0..999.9.
REQ-014 state  output  2  00 IDLE, 01 RUN, 10 WAIT, 11 HOLD.
REQ-015 sat  output  1  high when fare_bcd or dist_bcd has saturated at 9999.

Function
REQ-016 sw_start and pulse_in SHALL each pass through a 2-flop synchronizer; pulse_in edges SHALL be detected as rising edges of the synchronized signal, so an edge takes effect 3 clocks after the input toggles.
REQ-017 IDLE: fare_bcd=0, dist_bcd=0; a synchronized sw_start rising edge SHALL load fare_bcd=BASE_FARE, clear dist_bcd, the pulse counter and the idle counter, then enter RUN.
REQ-018 RUN: each detected edge SHALL increment the pulse counter; on reaching PULSES_PER_STEP it SHALL clear to 0 and dist_bcd SHALL increment by 1 in the same clock.
REQ-019 Each distance step whose post-increment step count exceeds BASE_STEPS SHALL add STEP_FARE to fare_bcd in the same clock as the dist_bcd update.
REQ-020 RUN: the idle counter SHALL clear on every detected edge; when it reaches IDLE_CYCLES, the state SHALL become WAIT and the wait counter SHALL clear.
REQ-021 WAIT: the wait counter SHALL count clocks; each time it reaches WAIT_UNIT it SHALL clear and WAIT_FARE SHALL be added to fare_bcd.
REQ-022 WAIT: a detected edge SHALL return the state to RUN next clock, count toward distance as in RUN, and clear the idle counter; a wait charge falling due in the same clock SHALL be discarded.
REQ-023 RUN or WAIT: synchronized sw_start low SHALL enter HOLD and freeze fare_bcd and dist_bcd; an edge in that same clock SHALL be ignored.
REQ-024 HOLD: outputs SHALL stay frozen; a sw_start rising edge SHALL start a new trip exactly as in REQ-017.
REQ-025 BCD addition SHALL add a single digit to the lowest digit with decimal carry ripple through all four digits in one clock; no digit SHALL ever hold a value above 9.
REQ-026 An addition that would exceed 9999 SHALL leave the field at 9999 and set sat; sat SHALL clear only on reset or a new-trip load.
REQ-027 The pulse counter, idle counter and wait counter SHALL be sized as clog2 of their parameter and SHALL never wrap.

Reset
REQ-028 rst_n low SHALL asynchronously force state=IDLE, fare_bcd=0, dist_bcd=0, sat=0, and all counters and synchronizers to 0, including in the middle of a trip.
REQ-029 After rst_n is released, a sw_start level that is already high SHALL NOT start a trip; a fresh rising edge is required.

Verification (PULSES_PER_STEP=2, BASE_STEPS=3, IDLE_CYCLES=20, WAIT_UNIT=10, other parameters default)
REQ-030 Reset, sw_start 0->1 -> state=01, fare_bcd=16'h0100, dist_bcd=0.
REQ-031 Apply 10 pulses -> dist_bcd=16'h0005, fare_bcd=16'h0104 (2 extra steps x 0.2).
REQ-032 No pulses for 20 clocks, then 30 more clocks -> state=10, fare_bcd rises by 3; one further pulse -> state=01.
REQ-033 Preload near limit via long run: fare reaches 999.9 -> fare_bcd=16'h9999, sat=1, no further change.
REQ-034 sw_start low mid-trip -> state=11, values frozen; sw_start high -> fare_bcd=16'h0100, dist_bcd=0, sat=0.
REQ-035 rst_n pulsed low during WAIT -> state=00, all outputs 0 immediately; a held-high sw_start does not restart the trip.

Source files
------------

// File: rtl/taxi_fare_calc.sv
// Taxi meter core: synchronizes the meter switch and wheel sensor, counts
// distance in 0.1 km BCD steps and accumulates a BCD fare from distance
// and waiting-time charges. Both fields saturate at 999.9.
module taxi_fare_calc #(
  parameter int          PULSES_PER_STEP = 10,
  parameter logic [15:0] BASE_FARE       = 16'h0100,
  parameter int          BASE_STEPS      = 30,
  parameter int          STEP_FARE       = 2,
  parameter int          IDLE_CYCLES     = 250_000_000,
  parameter int          WAIT_UNIT       = 500_000_000,
  parameter int          WAIT_FARE       = 1
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        sw_start,
  input  logic        pulse_in,
  output logic [15:0] fare_bcd,
  output logic [15:0] dist_bcd,
  output logic [1:0]  state,
  output logic        sat
);

  // Counters hold 0..PARAM-1 and clear on reaching PARAM, so clog2 bits suffice.
  localparam int PCNT_W = (PULSES_PER_STEP > 1) ? $clog2(PULSES_PER_STEP) : 1;
  localparam int ICNT_W = (IDLE_CYCLES > 1)     ? $clog2(IDLE_CYCLES)     : 1;
  localparam int WCNT_W = (WAIT_UNIT > 1)       ? $clog2(WAIT_UNIT)       : 1;

  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSES_PER_STEP - 1);
  localparam logic [ICNT_W-1:0] ICNT_LAST = ICNT_W'(IDLE_CYCLES - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_UNIT - 1);

  localparam logic [3:0] STEP_DIGIT = 4'(STEP_FARE);
  localparam logic [3:0] WAIT_DIGIT = 4'(WAIT_FARE);

  // Binary-to-BCD for elaboration-time constants; clamps at 9999.
  function automatic logic [15:0] to_bcd16(input int value);
    int v;
    logic [15:0] r;
    v = (value > 9999) ? 9999 : ((value < 0) ? 0 : value);
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // BASE_STEPS in BCD so it can be compared directly with the BCD distance;
  // BCD ordering of equal-width fields matches numeric ordering.
  localparam logic [15:0] BASE_STEPS_BCD = to_bcd16(BASE_STEPS);

  // Adds one digit (0..9) to the lowest BCD digit with ripple carry through
  // all four digits. Bit 16 of the result is the carry out of the top digit.
  function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [3:0] d);
    logic [4:0]  t;
    logic        c;
    logic [15:0] s;
    c = 1'b0;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      t = {1'b0, a[i*4 +: 4]} + ((i == 0) ? {1'b0, d} : 5'd0) + {4'd0, c};
      if (t > 5'd9) begin
        s[i*4 +: 4] = 4'(t - 5'd10);
        c = 1'b1;
      end else begin
        s[i*4 +: 4] = t[3:0];
        c = 1'b0;
      end
    end
    return {c, s};
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_WAIT = 2'b10,
    S_HOLD = 2'b11
  } state_t;

  state_t            r_state;
  logic              r_start_s1, r_start_s2, r_start_d;
  logic              r_pulse_s1, r_pulse_s2, r_pulse_d;
  logic [1:0]        r_fill;
  logic [PCNT_W-1:0] r_pcnt;
  logic [ICNT_W-1:0] r_idle;
  logic [WCNT_W-1:0] r_wait;
  logic [15:0]       r_fare;
  logic [15:0]       r_dist;
  logic              r_sat;

  logic        w_edge;
  logic        w_start_rise;
  logic        w_active;
  logic        w_step;
  logic        w_dist_ge_base;
  logic        w_wait_due;
  logic        w_fare_add;
  logic [3:0]  w_fare_digit;
  logic [16:0] w_fare_sum;
  logic [16:0] w_dist_sum;

  assign fare_bcd = r_fare;
  assign dist_bcd = r_dist;
  assign state    = r_state;
  assign sat      = r_sat;

  // Edge detection and selection of the single fare increment for this clock.
  always_comb begin
    w_edge = r_pulse_s2 & ~r_pulse_d;
    // r_start_d only holds a real sample once the synchronizer has refilled
    // after reset, so a switch already high at reset release is not an edge.
    w_start_rise   = r_start_s2 & ~r_start_d & (r_fill == 2'd3);
    w_active       = ((r_state == S_RUN) || (r_state == S_WAIT)) && r_start_s2;
    w_step         = w_edge && (r_pcnt == PCNT_LAST);
    w_dist_ge_base = (r_dist >= BASE_STEPS_BCD);
    w_wait_due     = (r_wait == WCNT_LAST);
    w_fare_add     = 1'b0;
    w_fare_digit   = 4'd0;
    if (w_active) begin
      if (w_step && w_dist_ge_base) begin
        // Post-increment distance exceeds BASE_STEPS iff the current one reaches it.
        w_fare_add   = 1'b1;
        w_fare_digit = STEP_DIGIT;
      end else if (!w_edge && (r_state == S_WAIT) && w_wait_due) begin
        // A wheel edge in the same clock wins and the wait charge is dropped.
        w_fare_add   = 1'b1;
        w_fare_digit = WAIT_DIGIT;
      end
    end
    w_fare_sum = bcd_add(r_fare, w_fare_digit);
    w_dist_sum = bcd_add(r_dist, 4'd1);
  end

  // Synchronizers, trip FSM, counters and the BCD fare/distance registers.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_start_s1 <= 1'b0;
      r_start_s2 <= 1'b0;
      r_start_d  <= 1'b0;
      r_pulse_s1 <= 1'b0;
      r_pulse_s2 <= 1'b0;
      r_pulse_d  <= 1'b0;
      r_fill     <= 2'd0;
      r_pcnt     <= '0;
      r_idle     <= '0;
      r_wait     <= '0;
      r_fare     <= '0;
      r_dist     <= '0;
      r_sat      <= 1'b0;
    end else begin
      r_start_s1 <= sw_start;
      r_start_s2 <= r_start_s1;
      r_start_d  <= r_start_s2;
      r_pulse_s1 <= pulse_in;
      r_pulse_s2 <= r_pulse_s1;
      r_pulse_d  <= r_pulse_s2;
      if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;

      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_start_rise) begin
            r_state <= S_RUN;
            r_fare  <= BASE_FARE;
            r_dist  <= '0;
            r_sat   <= 1'b0;
            r_pcnt  <= '0;
            r_idle  <= '0;
            r_wait  <= '0;
          end
        end
        S_RUN, S_WAIT: begin
          if (!r_start_s2) begin
            // Switch off freezes the meter; a wheel edge in this clock is ignored.
            r_state <= S_HOLD;
          end else if (w_edge) begin
            r_state <= S_RUN;
            r_idle  <= '0;
            r_wait  <= '0;
            if (w_step) begin
              r_pcnt <= '0;
              if (w_dist_sum[16]) begin
                r_dist <= 16'h9999;
                r_sat  <= 1'b1;
              end else begin
                r_dist <= w_dist_sum[15:0];
              end
            end else begin
              r_pcnt <= r_pcnt + 1'b1;
            end
          end else if (r_state == S_RUN) begin
            if (r_idle == ICNT_LAST) begin
              r_state <= S_WAIT;
              r_idle  <= '0;
              r_wait  <= '0;
            end else begin
              r_idle <= r_idle + 1'b1;
            end
          end else begin
            if (w_wait_due) r_wait <= '0;
            else            r_wait <= r_wait + 1'b1;
          end

          if (w_fare_add) begin
            if (w_fare_sum[16]) begin
              r_fare <= 16'h9999;
              r_sat  <= 1'b1;
            end else begin
              r_fare <= w_fare_sum[15:0];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_taxi_fare_calc.sv
// Bench for taxi_fare_calc: an integer meter model produces expected
// {state, sat, fare, dist} tuples that are queued when stimulus is driven
// and popped when the outputs are sampled.
module tb_taxi_fare_calc;

  localparam int PPS       = 2;
  localparam int BSTEPS    = 3;
  localparam int IDLE_CYC  = 20;
  localparam int WUNIT     = 10;
  localparam int STEP_FARE = 2;
  localparam int WAIT_FARE = 1;
  localparam int BASE_INT  = 100;

  logic        clk_50m = 1'b0;
  logic        rst_n;
  logic        sw_start;
  logic        pulse_in;
  logic [15:0] fare_bcd;
  logic [15:0] dist_bcd;
  logic [1:0]  state;
  logic        sat;

  int n_total = 0;
  int n_bad   = 0;

  logic [34:0] exp_q[$];

  int m_state;
  int m_fare;
  int m_dist;
  int m_pcnt;
  bit m_sat;

  // Clock and reset block: 50 MHz clock; reset is driven from the main sequence.
  always #10 clk_50m = ~clk_50m;

  taxi_fare_calc #(
    .PULSES_PER_STEP(PPS),
    .BASE_STEPS(BSTEPS),
    .IDLE_CYCLES(IDLE_CYC),
    .WAIT_UNIT(WUNIT)
  ) dut (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .sw_start(sw_start),
    .pulse_in(pulse_in),
    .fare_bcd(fare_bcd),
    .dist_bcd(dist_bcd),
    .state   (state),
    .sat     (sat)
  );

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push_exp();
    exp_q.push_back({2'(m_state), m_sat, to_bcd(m_fare), to_bcd(m_dist)});
  endtask

  task automatic compare_out(input string tag);
    logic [34:0] e;
    if (exp_q.size() == 0) begin
      n_total++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, "_state"}, 32'(state),    32'(e[34:33]));
      check_val({tag, "_sat"},   32'(sat),      32'(e[32]));
      check_val({tag, "_fare"},  32'(fare_bcd), 32'(e[31:16]));
      check_val({tag, "_dist"},  32'(dist_bcd), 32'(e[15:0]));
    end
  endtask

  // Integer meter model: one wheel edge while the trip is running.
  task automatic model_pulse();
    m_pcnt++;
    if (m_pcnt == PPS) begin
      m_pcnt = 0;
      if (m_dist == 9999) m_sat = 1'b1;
      else m_dist++;
      if (m_dist > BSTEPS) begin
        if (m_fare + STEP_FARE > 9999) begin
          m_fare = 9999;
          m_sat  = 1'b1;
        end else begin
          m_fare += STEP_FARE;
        end
      end
    end
  endtask

  task automatic model_new_trip();
    m_state = 1;
    m_fare  = BASE_INT;
    m_dist  = 0;
    m_pcnt  = 0;
    m_sat   = 1'b0;
  endtask

  task automatic model_reset();
    m_state = 0;
    m_fare  = 0;
    m_dist  = 0;
    m_pcnt  = 0;
    m_sat   = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  // Driver: n wheel pulses, each high for 'half' clocks then low for 'half' clocks.
  task automatic drive_pulses(input int n, input int half, input bit counted);
    for (int i = 0; i < n; i++) begin
      pulse_in = 1'b1;
      repeat (half) @(negedge clk_50m);
      pulse_in = 1'b0;
      repeat (half) @(negedge clk_50m);
      if (counted) model_pulse();
    end
  endtask

  task automatic wait_state(input string tag, input logic [1:0] st, input int budget);
    int k;
    k = 0;
    while (state !== st && k < budget) begin
      @(negedge clk_50m);
      k++;
    end
    check_val(tag, 32'(state), 32'(st));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    sw_start = 1'b0;
    pulse_in = 1'b0;
    model_reset();
    settle(3);
    push_exp();
    compare_out("reset");

    rst_n = 1'b1;
    settle(5);
    sw_start = 1'b1;
    settle(5);
    model_new_trip();
    push_exp();
    compare_out("start");

    // Distance exactly at BASE_STEPS: no step charge yet.
    drive_pulses(6, 2, 1'b1);
    settle(3);
    push_exp();
    compare_out("dist3");

    drive_pulses(4, 2, 1'b1);
    settle(3);
    push_exp();
    compare_out("dist5");

    // Idle into WAIT, then waiting charges at every WAIT_UNIT clocks.
    wait_state("to_wait", 2'b10, 40);
    m_state = 2;
    push_exp();
    compare_out("wait_entry");
    repeat (9) @(posedge clk_50m);
    #1;
    push_exp();
    compare_out("wait_c9");
    @(posedge clk_50m);
    #1;
    m_fare += WAIT_FARE;
    push_exp();
    compare_out("wait_c10");
    repeat (23) @(posedge clk_50m);
    #1;
    m_fare += 2 * WAIT_FARE;
    push_exp();
    compare_out("wait_c33");

    @(negedge clk_50m);
    drive_pulses(1, 2, 1'b1);
    settle(3);
    m_state = 1;
    push_exp();
    compare_out("wait_to_run");

    // Long fast run drives the fare into saturation.
    drive_pulses(9999, 1, 1'b1);
    settle(4);
    push_exp();
    compare_out("long_run");

    drive_pulses(2, 1, 1'b1);
    settle(4);
    push_exp();
    compare_out("sat_stays");

    // Switch off: HOLD freezes everything and ignores wheel pulses.
    sw_start = 1'b0;
    settle(5);
    m_state = 3;
    push_exp();
    compare_out("hold");
    drive_pulses(2, 2, 1'b0);
    settle(25);
    push_exp();
    compare_out("hold_frozen");

    sw_start = 1'b1;
    settle(5);
    model_new_trip();
    push_exp();
    compare_out("new_trip");

    // Asynchronous reset in the middle of WAIT.
    wait_state("to_wait2", 2'b10, 40);
    @(negedge clk_50m);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    push_exp();
    compare_out("rst_async");
    settle(2);
    rst_n = 1'b1;
    settle(10);
    push_exp();
    compare_out("rst_no_restart");

    sw_start = 1'b0;
    settle(4);
    sw_start = 1'b1;
    settle(5);
    model_new_trip();
    push_exp();
    compare_out("restart");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
